alu_decode_exec_mc: RTL and testbench
=====================================

// Module: alu_decode_exec_mc
// PURPOSE
//   Parametrised successor to the combinational ALU decoder: decodes ALUOp/funct3/funct7/op5 into
//   the full RV32I ALU operation set (adds SLT, SLTU, SRA) and executes it. Simple ops take 1 cycle;
//   shifts use an iterative shifter of SHIFT_STEP bits/cycle. A valid/ready handshake on both sides
//   lets it sit between decode and writeback of a multi-cycle datapath.
// PARAMETERS
//   XLEN        32  operand/result width; power of 2, >= 8
//   SHIFT_STEP  1   max shift distance per cycle; power of 2, 1..XLEN
// PORTS
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous, active-high reset
//   in_valid   in   1     operation request valid
//   in_ready   out  1     block can accept a request this cycle
//   alu_op     in   2     00 add, 01 sub, 10 decode by funct3, 11 add
//   funct3     in   3     instruction funct3
//   funct7b5   in   1     instruction bit 30
//   op5        in   1     opcode bit 5 (1 = R-type, 0 = I-type)
//   src_a      in   XLEN  operand A
//   src_b      in   XLEN  operand B; shamt = src_b[$clog2(XLEN)-1:0]
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  operation result
//   zero       out  1     result == 0
//   alu_ctrl   out  4     registered decoded op code of the current/last op
//   busy       out  1     high in SHIFT state
// BEHAVIOUR
//   Decode (alu_ctrl): ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110,
//     SRA 0111, OR 1000, AND 1001. alu_op=10: f3 000 -> SUB if op5&funct7b5, else ADD;
//     001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if funct7b5, else SRL (op5 ignored);
//     110 OR; 111 AND.
//   Arithmetic: ADD/SUB modulo 2^XLEN; SLT signed, SLTU unsigned, result zero-extended 0/1.
//   FSM states IDLE, SHIFT, DONE. Accept = in_valid & in_ready; in_ready = IDLE | (DONE & out_ready).
//   Accept with non-shift op, or shift with shamt==0: result registered -> DONE next cycle.
//   Accept with shift and shamt>0: load shreg=src_a, cnt=shamt -> SHIFT. Each SHIFT cycle: shift by
//     min(cnt, SHIFT_STEP) (SRA fills sign bit, SLL/SRL fill 0), cnt -= that; cnt hits 0 -> DONE.
//   Latency (accept edge to out_valid): 1 cycle simple; 1 + ceil(shamt/SHIFT_STEP) for shifts.
//   DONE: out_valid=1; result, zero, alu_ctrl held stable until out_valid & out_ready.
//     Handshake w/o new accept -> IDLE; with simultaneous accept -> new op's next state (back-to-back).
//   Inputs are sampled only on the accept cycle; later changes have no effect.
//   Reset: state IDLE, out_valid 0, result 0, zero 0 (not 1), alu_ctrl 0000, busy 0, cnt 0.
//     Reset in SHIFT or DONE aborts the op; no result is emitted; in_ready=1 the cycle after.
// TESTING
//   1 alu_op=10 f3=000 op5=1 f7b5=0, a=5 b=7 -> result 12, zero 0, alu_ctrl 0000, out_valid 1 cycle later.
//   2 same w/ f7b5=1, a=7 b=7 -> result 0, zero 1; op5=0 f7b5=1 a=7 b=7 -> result 14 (ADDI).
//   3 STEP=1: SRA a=0x80000000 b=4 -> 0xF8000000, out_valid at accept+5; SLL b=0 -> a at accept+1;
//     STEP=8: SRL a=0xFFFFFFFF b=31 -> 0x00000001, out_valid at accept+5.
//   4 a=0xFFFFFFFF b=1: SLT -> 1, SLTU -> 0; alu_op=01 a=3 b=5 -> 0xFFFFFFFE.
//   5 out_ready low 3 cycles in DONE -> result held, in_ready 0; raise out_ready w/ in_valid=1 ->
//     accept same cycle, next result 1 cycle later.
//   6 SLL shamt=31 STEP=1, rst at SHIFT cycle 10 -> out_valid never asserts, in_ready 1 after reset.

Source files
------------

// File: rtl/alu_decode_exec_mc.sv
// RV32I ALU decoder and executor with valid/ready handshakes on both sides.
// Simple ops finish in one cycle; shifts run on an iterative shifter of SHIFT_STEP bits per cycle.
module alu_decode_exec_mc #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            op5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [3:0]      dec_ctrl;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            start_shift;
  logic            accept;
  logic [XLEN-1:0] alu_res;

  logic [XLEN-1:0] shreg;
  logic [SHW-1:0]  cnt;
  logic [CW-1:0]   cnt_ext;
  logic [CW-1:0]   step_w;
  logic [SHW-1:0]  step;
  logic [SHW-1:0]  cnt_nxt;
  logic [XLEN-1:0] shifted;

  // Instruction field decode into the ALU control code
  always_comb begin
    dec_ctrl = OP_ADD;
    case (alu_op)
      2'b01: dec_ctrl = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = (op5 & funct7b5) ? OP_SUB : OP_ADD;
          3'b001:  dec_ctrl = OP_SLL;
          3'b010:  dec_ctrl = OP_SLT;
          3'b011:  dec_ctrl = OP_SLTU;
          3'b100:  dec_ctrl = OP_XOR;
          3'b101:  dec_ctrl = funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  dec_ctrl = OP_OR;
          default: dec_ctrl = OP_AND;
        endcase
      end
      default: dec_ctrl = OP_ADD;
    endcase
  end

  assign shamt       = src_b[SHW-1:0];
  assign is_shift    = (dec_ctrl == OP_SLL) || (dec_ctrl == OP_SRL) || (dec_ctrl == OP_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign accept      = in_valid & in_ready;

  // Single-cycle result; shifts only reach here with shamt == 0
  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SLT:  alu_res[0] = $signed(src_a) < $signed(src_b);
      OP_SLTU: alu_res[0] = src_a < src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $signed(src_a) >>> shamt;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      default: alu_res = '0;
    endcase
  end

  // One iterative shift step of min(cnt, SHIFT_STEP); compared one bit wider so STEP == XLEN fits
  always_comb begin
    cnt_ext = CW'(cnt);
    step_w  = (cnt_ext < CW'(SHIFT_STEP)) ? cnt_ext : CW'(SHIFT_STEP);
    step    = SHW'(step_w);
    cnt_nxt = cnt - step;
    case (alu_ctrl)
      OP_SLL:  shifted = shreg << step;
      OP_SRA:  shifted = $signed(shreg) >>> step;
      default: shifted = shreg >> step;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (cnt_nxt == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = start_shift ? S_SHIFT : S_DONE;
          else          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture, shifter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      alu_ctrl <= OP_ADD;
      shreg    <= '0;
      cnt      <= '0;
    end else if (accept) begin
      alu_ctrl <= dec_ctrl;
      if (start_shift) begin
        shreg <= src_a;
        cnt   <= shamt;
      end else begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end
    end else if (state_q == S_SHIFT) begin
      shreg <= shifted;
      cnt   <= cnt_nxt;
      if (cnt_nxt == '0) begin
        result <= shifted;
        zero   <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_exec_mc.sv
// Directed bench for alu_decode_exec_mc: one instance with SHIFT_STEP=1, one with SHIFT_STEP=8.
module tb_alu_decode_exec_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  aop;
  logic [2:0]  f3;
  logic        f7;
  logic        o5;
  logic [31:0] a, b;
  logic        ordy;
  logic        v1, v8;

  logic        rdy1, ov1, z1, busy1;
  logic [31:0] res1;
  logic [3:0]  ctl1;
  logic        rdy8, ov8, z8, busy8;
  logic [31:0] res8;
  logic [3:0]  ctl8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_decode_exec_mc #(.XLEN(32), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
    .alu_op(aop), .funct3(f3), .funct7b5(f7), .op5(o5),
    .src_a(a), .src_b(b), .out_valid(ov1), .out_ready(ordy),
    .result(res1), .zero(z1), .alu_ctrl(ctl1), .busy(busy1)
  );

  alu_decode_exec_mc #(.XLEN(32), .SHIFT_STEP(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .alu_op(aop), .funct3(f3), .funct7b5(f7), .op5(o5),
    .src_a(a), .src_b(b), .out_valid(ov8), .out_ready(ordy),
    .result(res8), .zero(z8), .alu_ctrl(ctl8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble the operands after accept, and count cycles until out_valid
  task automatic run_op(input bit s8, input logic [1:0] op, input logic [2:0] f,
                        input logic b5, input logic o, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] r, output logic z, output logic [3:0] c, output int lat);
    @(negedge clk);
    aop = op; f3 = f; f7 = b5; o5 = o; a = va; b = vb;
    if (s8) v8 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v8 = 1'b0; a = ~va; b = ~vb;
    lat = 1;
    while (!(s8 ? ov8 : ov1) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    r = s8 ? res8 : res1;
    z = s8 ? z8 : z1;
    c = s8 ? ctl8 : ctl1;
  endtask

  logic [31:0] r;
  logic        z;
  logic [3:0]  c;
  int          lat;
  bit          seen_valid;

  initial begin
    rst = 1'b1; ordy = 1'b1; v1 = 1'b0; v8 = 1'b0;
    aop = 2'b00; f3 = 3'b000; f7 = 1'b0; o5 = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst result", res1, 32'h0);
    chk("rst zero", 32'(z1), 32'h0);
    chk("rst ctrl", 32'(ctl1), 32'h0);
    chk("rst out_valid", 32'(ov1), 32'h0);
    chk("rst busy", 32'(busy1), 32'h0);
    chk("rst in_ready", 32'(rdy1), 32'h1);

    run_op(1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 32'd5, 32'd7, r, z, c, lat);
    chk("add res", r, 32'd12);
    chk("add zero", 32'(z), 32'h0);
    chk("add ctrl", 32'(c), 32'h0);
    chk("add lat", 32'(lat), 32'd1);

    run_op(1'b0, 2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd7, r, z, c, lat);
    chk("sub res", r, 32'd0);
    chk("sub zero", 32'(z), 32'h1);
    chk("sub ctrl", 32'(c), 32'h1);

    run_op(1'b0, 2'b10, 3'b000, 1'b1, 1'b0, 32'd7, 32'd7, r, z, c, lat);
    chk("addi res", r, 32'd14);
    chk("addi ctrl", 32'(c), 32'h0);

    run_op(1'b0, 2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, r, z, c, lat);
    chk("sra1 res", r, 32'hF800_0000);
    chk("sra1 ctrl", 32'(c), 32'h7);
    chk("sra1 lat", 32'(lat), 32'd5);

    run_op(1'b0, 2'b10, 3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'd0, r, z, c, lat);
    chk("sll0 res", r, 32'h1234_5678);
    chk("sll0 ctrl", 32'(c), 32'h2);
    chk("sll0 lat", 32'(lat), 32'd1);

    run_op(1'b0, 2'b10, 3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd3, r, z, c, lat);
    chk("srl1 res", r, 32'h1000_0000);
    chk("srl1 lat", 32'(lat), 32'd4);

    run_op(1'b1, 2'b10, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd31, r, z, c, lat);
    chk("srl8 res", r, 32'h0000_0001);
    chk("srl8 ctrl", 32'(c), 32'h6);
    chk("srl8 lat", 32'(lat), 32'd5);

    run_op(1'b1, 2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd17, r, z, c, lat);
    chk("sra8 res", r, 32'hFFFF_C000);
    chk("sra8 lat", 32'(lat), 32'd4);

    run_op(1'b1, 2'b10, 3'b001, 1'b0, 1'b1, 32'd1, 32'd8, r, z, c, lat);
    chk("sll8 res", r, 32'h0000_0100);
    chk("sll8 lat", 32'(lat), 32'd2);

    run_op(1'b0, 2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, r, z, c, lat);
    chk("slt res", r, 32'd1);
    chk("slt ctrl", 32'(c), 32'h3);

    run_op(1'b0, 2'b10, 3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, r, z, c, lat);
    chk("sltu res", r, 32'd0);
    chk("sltu zero", 32'(z), 32'h1);
    chk("sltu ctrl", 32'(c), 32'h4);

    run_op(1'b0, 2'b01, 3'b111, 1'b0, 1'b0, 32'd3, 32'd5, r, z, c, lat);
    chk("aop01 res", r, 32'hFFFF_FFFE);
    chk("aop01 ctrl", 32'(c), 32'h1);

    run_op(1'b0, 2'b10, 3'b100, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, r, z, c, lat);
    chk("xor res", r, 32'h0000_0FF0);
    chk("xor ctrl", 32'(c), 32'h5);
    run_op(1'b0, 2'b10, 3'b110, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, r, z, c, lat);
    chk("or res", r, 32'h0000_FFF0);
    chk("or ctrl", 32'(c), 32'h8);
    run_op(1'b0, 2'b10, 3'b111, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, r, z, c, lat);
    chk("and res", r, 32'h0000_F000);
    chk("and ctrl", 32'(c), 32'h9);

    run_op(1'b0, 2'b11, 3'b001, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, r, z, c, lat);
    chk("aop11 wrap res", r, 32'h0);
    chk("aop11 zero", 32'(z), 32'h1);
    chk("aop11 ctrl", 32'(c), 32'h0);

    // Backpressure: result held while out_ready is low, then back-to-back accept
    @(posedge clk); #1;
    ordy = 1'b0;
    run_op(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, r, z, c, lat);
    chk("bp first res", r, 32'd3);
    aop = 2'b00; a = 32'd10; b = 32'd20; v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp hold res", res1, 32'd3);
      chk("bp hold valid", 32'(ov1), 32'h1);
      chk("bp hold in_ready", 32'(rdy1), 32'h0);
    end
    @(negedge clk);
    ordy = 1'b1;
    #1 chk("bp in_ready", 32'(rdy1), 32'h1);
    @(posedge clk); #1;
    v1 = 1'b0;
    chk("b2b valid", 32'(ov1), 32'h1);
    chk("b2b res", res1, 32'd30);

    // Reset in the middle of a long shift aborts it
    @(posedge clk); #1;
    @(negedge clk);
    aop = 2'b10; f3 = 3'b001; f7 = 1'b0; o5 = 1'b1; a = 32'd1; b = 32'd31; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort busy", 32'(busy1), 32'h1);
    chk("abort no valid", 32'(ov1), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort in_ready", 32'(rdy1), 32'h1);
    chk("abort busy clr", 32'(busy1), 32'h0);
    chk("abort result", res1, 32'h0);
    chk("abort zero", 32'(z1), 32'h0);
    chk("abort ctrl", 32'(ctl1), 32'h0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov1) seen_valid = 1'b1;
    end
    chk("abort never valid", 32'(seen_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
